// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 key sequencer.
// Imported by the FIFO and the sequencer top.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT  = 8'hE0;
  localparam logic [7:0] PS2_BRK  = 8'hF0;
  localparam logic [7:0] PS2_ERR0 = 8'h00;
  localparam logic [7:0] PS2_ERR1 = 8'hFF;

  // E0-prefixed shift codes some keyboards inject
  localparam logic [7:0] PS2_FAKE0 = 8'h12;
  localparam logic [7:0] PS2_FAKE1 = 8'h59;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

endpackage

// File: rtl/ps2_event_fifo.sv
// Event FIFO: drop-on-full with sticky overflow flag.
// Head entry is shown combinationally from storage.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     i_push,
  input  ps2_evt_t i_data,
  output logic     o_full,
  input  logic     i_pop,
  output logic     o_empty,
  output ps2_evt_t o_head,
  input  logic     i_ovf_clr,
  output logic     o_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  ps2_evt_t      r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;
  logic          r_ovf;

  logic w_pop;
  logic w_push;
  logic w_drop;

  assign o_full     = (r_cnt == (AW+1)'(FIFO_DEPTH));
  assign o_empty    = (r_cnt == '0);
  assign o_head     = r_mem[r_rd];
  assign o_overflow = r_ovf;

  // A pop frees the slot, so a push to a full FIFO may proceed
  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);
  assign w_drop = i_push & o_full & ~w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      if (w_drop)         r_ovf <= 1'b1;
      else if (i_ovf_clr) r_ovf <= 1'b0;
    end
  end

endmodule

// File: rtl/ps2_key_sequencer.sv
// PS/2 set-2 prefix decoder: folds E0/F0 prefixes into
// {ext,brk,code} events queued for a valid/ready consumer.
module ps2_key_sequencer
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2500000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  input  logic       evt_ready,
  output logic       evt_valid,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_brk,
  input  logic       ovf_clr,
  output logic       overflow
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  ps2_state_e r_state;
  logic [CW-1:0] r_cnt;
  logic     r_push;
  ps2_evt_t r_evt;

  logic     w_is_ext;
  logic     w_is_brk;
  logic     w_is_err;
  logic     w_is_fake;
  logic     w_st_ext;
  logic     w_st_brk;
  logic     w_full;
  logic     w_empty;
  ps2_evt_t w_head;

  assign w_is_ext  = (byte_data == PS2_EXT);
  assign w_is_brk  = (byte_data == PS2_BRK);
  assign w_is_err  = (byte_data == PS2_ERR0) |
                     (byte_data == PS2_ERR1);
  assign w_is_fake = (byte_data == PS2_FAKE0) |
                     (byte_data == PS2_FAKE1);
  assign w_st_ext  = (r_state == EXT) | (r_state == EXT_BRK);
  assign w_st_brk  = (r_state == BRK) | (r_state == EXT_BRK);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_push  <= 1'b0;
      r_evt   <= '0;
    end else begin
      r_push <= 1'b0;
      if (byte_valid) begin
        r_cnt <= '0;
        unique case (1'b1)
          w_is_ext: r_state <= w_st_brk ? EXT_BRK : EXT;
          w_is_brk: r_state <= w_st_ext ? EXT_BRK : BRK;
          w_is_err: r_state <= IDLE;
          default: begin
            r_state <= IDLE;
            if (!(w_st_ext && w_is_fake)) begin
              r_push   <= 1'b1;
              r_evt.ext  <= w_st_ext;
              r_evt.brk  <= w_st_brk;
              r_evt.code <= byte_data;
            end
          end
        endcase
      end else if (r_state == IDLE) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
        r_state <= IDLE;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  ps2_event_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (resetn),
    .i_push    (r_push),
    .i_data    (r_evt),
    .o_full    (w_full),
    .i_pop     (evt_ready),
    .o_empty   (w_empty),
    .o_head    (w_head),
    .i_ovf_clr (ovf_clr),
    .o_overflow(overflow)
  );

  assign evt_valid = ~w_empty;
  assign evt_code  = w_head.code;
  assign evt_ext   = w_head.ext;
  assign evt_brk   = w_head.brk;

  logic w_unused;
  assign w_unused = w_full;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Directed bench for ps2_key_sequencer with hand-computed events.
// Inputs change and outputs are sampled on the falling edge.
module tb_ps2_key_sequencer;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic       evt_ready = 1'b0;
  logic       evt_valid;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_brk;
  logic       ovf_clr = 1'b0;
  logic       overflow;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ps2_key_sequencer #(
    .TIMEOUT_CYCLES(16),
    .FIFO_DEPTH    (4)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .evt_ready (evt_ready),
    .evt_valid (evt_valid),
    .evt_code  (evt_code),
    .evt_ext   (evt_ext),
    .evt_brk   (evt_brk),
    .ovf_clr   (ovf_clr),
    .overflow  (overflow)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    @(negedge clk);
    byte_valid = 1'b0;
    byte_data  = 8'h00;
  endtask

  // expected head as {ext,brk,code}
  task automatic expect_evt(input string tag,
                            input logic [9:0] exp);
    chk({tag, "_vld"}, 32'(evt_valid), 32'd1);
    chk({tag, "_evt"}, 32'({evt_ext, evt_brk, evt_code}),
        32'(exp));
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_vld"}, 32'(evt_valid), 32'd0);
    chk({tag, "_evt"}, 32'({evt_ext, evt_brk, evt_code}),
        32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    // reset state
    #2;
    chk_reset_outs("rst");
    tick();
    tick();
    resetn = 1'b1;

    // make then break of 1C, one-cycle emit latency
    evt_ready = 1'b1;
    send(8'h1C);
    chk("mk_lat", 32'(evt_valid), 32'd0);
    tick();
    expect_evt("mk", 10'h01C);
    send(8'hF0);
    chk("mk_pop", 32'(evt_valid), 32'd0);
    send(8'h1C);
    chk("brk_lat", 32'(evt_valid), 32'd0);
    tick();
    expect_evt("brk", 10'h11C);
    tick();
    chk("brk_pop", 32'(evt_valid), 32'd0);

    // extended make / break, fake shift dropped
    send(8'hE0);
    send(8'h75);
    tick();
    expect_evt("xmk", 10'h275);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    tick();
    expect_evt("xbrk", 10'h375);
    send(8'hE0);
    send(8'h12);
    tick();
    tick();
    chk("fake", 32'(evt_valid), 32'd0);
    send(8'h1C);
    tick();
    expect_evt("fake_idle", 10'h01C);
    tick();

    // error byte after prefix drops and returns to IDLE
    send(8'hF0);
    send(8'hFF);
    send(8'h1C);
    tick();
    expect_evt("err_idle", 10'h01C);
    tick();

    // overflow: six makes into a 4-deep FIFO
    evt_ready = 1'b0;
    send(8'h15);
    send(8'h1D);
    send(8'h24);
    send(8'h2D);
    send(8'h2C);
    send(8'h35);
    tick();
    chk("ovf_set", 32'(overflow), 32'd1);
    expect_evt("ovf_h0", 10'h015);
    tick();
    expect_evt("ovf_hold", 10'h015);
    evt_ready = 1'b1;
    expect_evt("dr0", 10'h015);
    tick();
    expect_evt("dr1", 10'h01D);
    tick();
    expect_evt("dr2", 10'h024);
    tick();
    expect_evt("dr3", 10'h02D);
    tick();
    chk("dr_empty", 32'(evt_valid), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);

    // full FIFO with simultaneous pop and push
    evt_ready = 1'b0;
    send(8'h15);
    send(8'h1D);
    send(8'h24);
    send(8'h2D);
    tick();
    send(8'h2C);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    chk("fp_novf", 32'(overflow), 32'd0);
    expect_evt("fp_head", 10'h01D);
    evt_ready = 1'b1;
    tick();
    expect_evt("fp1", 10'h024);
    tick();
    expect_evt("fp2", 10'h02D);
    tick();
    expect_evt("fp3", 10'h02C);
    tick();
    chk("fp_empty", 32'(evt_valid), 32'd0);

    // overflow beats ovf_clr on the same cycle
    evt_ready = 1'b0;
    send(8'h15);
    send(8'h1D);
    send(8'h24);
    send(8'h2D);
    tick();
    send(8'h2C);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_win", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr2", 32'(overflow), 32'd0);
    evt_ready = 1'b1;
    repeat (4) tick();
    chk("ovw_empty", 32'(evt_valid), 32'd0);

    // byte on the expiry cycle still sees the prefix
    send(8'hE0);
    repeat (15) tick();
    send(8'h1C);
    tick();
    expect_evt("to_edge", 10'h21C);
    tick();

    // full timeout drops the prefix
    send(8'hE0);
    repeat (16) tick();
    send(8'h1C);
    tick();
    expect_evt("to_exp", 10'h01C);
    tick();

    // reset mid-sequence with a pending event and overflow
    evt_ready = 1'b0;
    send(8'h15);
    send(8'h1D);
    send(8'h24);
    send(8'h2D);
    send(8'h2C);
    tick();
    chk("pre_ovf", 32'(overflow), 32'd1);
    send(8'hF0);
    resetn = 1'b0;
    #1;
    chk_reset_outs("mid_rst");
    tick();
    chk_reset_outs("mid_rst2");
    resetn = 1'b1;
    evt_ready = 1'b1;
    send(8'h1C);
    chk("post_lat", 32'(evt_valid), 32'd0);
    tick();
    expect_evt("post_rst", 10'h01C);
    tick();
    chk("post_pop", 32'(evt_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_key_sequencer.md
PS2_KEY_SEQUENCER -- requirements
Module: ps2_key_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 2500000: idle clk cycles in a prefix state before forced return to IDLE.
REQ-002 Parameter FIFO_DEPTH, default 4: event FIFO entries; power of two, at least 2.
REQ-003 clk  input  1  single system clock; all logic on posedge clk.
REQ-004 resetn  input  1  reset, asynchronous assert, active-low.
REQ-005 byte_valid  input  1  one-cycle pulse per received PS/2 byte, synchronous to clk.
REQ-006 byte_data  input  8  received scan byte; sampled only when byte_valid=1.
REQ-007 evt_ready  input  1  consumer accepts the head event this cycle.
REQ-008 evt_valid  output  1  head event present.
REQ-009 evt_code  output  8  key scan code, without prefixes.
REQ-010 evt_ext  output  1  key was E0-prefixed.
REQ-011 evt_brk  output  1  1=release (F0-prefixed), 0=press.
REQ-012 ovf_clr  input  1  clears overflow.
REQ-013 overflow  output  1  sticky: an event was dropped because the FIFO was full.

Function
REQ-014 The FSM SHALL have four states: IDLE, EXT, BRK and EXT_BRK; it advances only on cycles with byte_valid=1.
REQ-015 In IDLE: E0->EXT; F0->BRK; 00 or FF->drop, stay IDLE; any other byte->emit {ext=0,brk=0}, stay IDLE.
REQ-016 In EXT: E0->stay EXT; F0->EXT_BRK; 00 or FF->drop, go IDLE; other->emit {ext=1,brk=0}, go IDLE.
REQ-017 In BRK: F0->stay BRK; E0->EXT_BRK; 00 or FF->drop, go IDLE; other->emit {ext=0,brk=1}, go IDLE.
REQ-018 In EXT_BRK: E0 or F0->stay; 00 or FF->drop, go IDLE; other->emit {ext=1,brk=1}, go IDLE.
REQ-019 Extended codes 12 and 59 (fake shifts) SHALL be dropped without emitting; the FSM still returns to IDLE.
REQ-020 Emit latency: evt_valid SHALL rise on the clk edge after the one sampling the terminating byte_valid when the FIFO was empty.
REQ-021 Timeout counter: cleared on byte_valid and while in IDLE; increments otherwise; on reaching TIMEOUT_CYCLES-1 the FSM SHALL go to IDLE and the counter SHALL clear.
REQ-022 byte_valid on the same cycle as timeout expiry SHALL take priority; the byte is processed from the current state.
REQ-023 FIFO pop occurs when evt_valid and evt_ready are both 1; outputs SHALL show the next entry, or drop evt_valid, on the next edge.
REQ-024 evt_code, evt_ext and evt_brk SHALL hold stable while evt_valid=1 and evt_ready=0.
REQ-025 Push when full with no pop: the new event SHALL be dropped and overflow set; existing entries are unchanged.
REQ-026 Push when full with a simultaneous pop: both SHALL occur; no overflow.
REQ-027 Push and pop on an empty FIFO cannot coincide; evt_valid=0 means no pop.
REQ-028 ovf_clr clears overflow; an overflow event on the same cycle SHALL win, leaving overflow=1.
REQ-029 Pointers SHALL wrap modulo FIFO_DEPTH; the occupancy count is log2(FIFO_DEPTH)+1 bits wide.

Reset
REQ-030 resetn=0 SHALL immediately set state=IDLE, FIFO empty, counter=0, evt_valid=0, evt_code=00, evt_ext=0, evt_brk=0 and overflow=0.
REQ-031 Reset mid-sequence, for example after E0, SHALL discard the prefix; the next byte is treated from IDLE.
REQ-032 Reset release SHALL be taken synchronously; first byte accepted on the first edge with resetn=1.

Structure
REQ-033 Shared package ps2_pkg SHALL hold: FSM state enum, constants PS2_EXT=E0, PS2_BRK=F0, PS2_ERR0=00, PS2_ERR1=FF, and the 10-bit event struct {ext,brk,code}.
REQ-034 The FIFO SHALL be a sub-module ps2_event_fifo, parameterised by FIFO_DEPTH, with push/full/pop/empty/overflow ports.
REQ-035 The prefix FSM and timeout counter SHALL reside in ps2_key_sequencer.

Verification
REQ-036 Bytes 1C; F0 1C with evt_ready=1 -> events {1C,ext0,brk0}, then {1C,ext0,brk1}; each evt_valid rises one cycle after its last byte.
REQ-037 Bytes E0 75; E0 F0 75; E0 12 -> events {75,1,0} and {75,1,1} only; E0 12 produces no event.
REQ-038 evt_ready=0; six make codes 15,1D,24,2D,2C,35 -> FIFO holds 15,1D,24,2D; overflow=1; drain yields exactly those four in order.
REQ-039 FIFO full, evt_ready=1 while the fifth byte completes -> no overflow; head advances; the new event is queued at the tail.
REQ-040 Byte E0, then TIMEOUT_CYCLES idle cycles (use TIMEOUT_CYCLES=16), then 1C -> event {1C,0,0}.
REQ-041 Byte F0, then resetn=0 for one cycle mid-gap, then 1C -> event {1C,0,0}; all outputs were at their reset values during reset.
